hazard_freeze_ctrl: RTL and testbench
=====================================

Name: hazard_freeze_ctrl

Overview:
- Pipeline sequencing controller for the 5-stage ARM-style core: IF, ID, EXE, MEM, WB.
- Watches the ID-stage source registers against in-flight EXE/MEM destinations, taken branches, and the multicycle data-memory handshake.
- Drives freeze, flush and bubble controls for the PC and the IF/ID, ID/EXE, EXE/MEM and MEM/WB pipeline registers.
- Keeps saturating performance counters and a sticky memory-timeout flag.

Parameters:
MEM_TIMEOUT, 64, MEM_WAIT cycle count at which mem_timeout sets (range 1..65535)
CNT_W, 16, width of the performance counters

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous, active-high reset
id_valid  in  1  ID holds a real (non-bubble, condition-passed) instruction
id_src_rn  in  4  ID first source register (Instruction[19:16])
id_src_rm  in  4  ID second source register (Rm, or Rd for stores)
id_uses_rn  in  1  instruction reads Rn (0 for MOV/MVN/B)
id_two_src  in  1  instruction reads the second source (register operand or store)
exe_dest  in  4  EXE-stage destination
exe_wb_en  in  1  EXE-stage writes back
exe_mem_read  in  1  EXE-stage instruction is a load
mem_dest  in  4  MEM-stage destination
mem_wb_en  in  1  MEM-stage writes back
branch_taken  in  1  EXE-stage branch is taken this cycle
mem_req  in  1  MEM stage issues a load or store this cycle
mem_ready  in  1  data memory completes the request this cycle
freeze_pc  out  1  hold PC
freeze_if_id  out  1  hold IF/ID register
freeze_back  out  1  hold ID/EXE, EXE/MEM and MEM/WB registers
flush_if_id  out  1  clear IF/ID to a NOP next edge
bubble_id_exe  out  1  load ID/EXE with zeroed control signals
fwd_sel_rn  out  2  Rn operand source: 00 regfile, 01 EXE result, 10 MEM result
fwd_sel_rm  out  2  same encoding, second source
stall_count  out  CNT_W  saturating count of cycles with freeze_pc=1
flush_count  out  CNT_W  saturating count of branch flushes
mem_timeout  out  1  sticky: a memory wait reached MEM_TIMEOUT

Behaviour:
- Reset, asynchronous: state=RUN; wait_cnt, stall_count, flush_count and mem_timeout all 0. The combinational outputs then follow the rules below (all 0 when inputs are idle).
- The FSM has states RUN and MEM_WAIT. The control outputs are combinational from the state and inputs; only the FSM, wait_cnt, counters and flag are registered.
- Memory freeze, highest priority:
  - mfz = mem_req & ~mem_ready.
  - When mfz=1: freeze_pc=freeze_if_id=freeze_back=1; flush_if_id=0; bubble_id_exe=0. Branch and hazard are ignored, because the stages are frozen and re-evaluate later.
- FSM transitions:
  - RUN -> MEM_WAIT when mfz=1; wait_cnt <= 1.
  - MEM_WAIT stays while mfz=1; wait_cnt increments, saturating at MEM_TIMEOUT.
  - MEM_WAIT -> RUN on the edge where mfz=0; wait_cnt <= 0.
  - mem_timeout <= 1 on the edge where wait_cnt == MEM_TIMEOUT-1 and mfz=1. It clears only on rst.
- Branch, when mfz=0 and branch_taken=1:
  - flush_if_id=1 and bubble_id_exe=1, squashing the IF and ID instructions.
  - freeze_pc=0, so the PC loads the target.
  - The ID hazard is ignored.
  - flush_count increments once per cycle with branch_taken=1 under these conditions.
- Hazard, when mfz=0, branch_taken=0 and id_valid=1:
  - hz_exe = exe_wb_en & ((id_uses_rn & exe_dest==id_src_rn) | (id_two_src & exe_dest==id_src_rm)).
  - hz_mem is the same with mem_wb_en and mem_dest.
  - Without forwarding, hz = hz_exe | hz_mem.
  - When hz=1: freeze_pc=freeze_if_id=1, bubble_id_exe=1, freeze_back=0.
- stall_count increments on every edge where freeze_pc=1 and holds at 2^CNT_W-1.
- Reset mid-wait returns to RUN immediately; the counters clear.
- R15 has no special treatment: a comparison on register 15 behaves like any other register.
- With id_valid=0, no hazard is raised and fwd_sel is 00.

Optional Feature:
Macro FORWARDING_EN.
- When defined:
  - hz = hz_exe & exe_mem_read (load-use only).
  - fwd_sel_rn=01 when EXE matches Rn; otherwise 10 when MEM matches Rn; otherwise 00. EXE has priority over MEM.
  - fwd_sel_rm is computed the same way for Rm.
  - A source whose use bit is 0 gets fwd_sel=00.
  - fwd_sel is forced to 00 when hz=1, mfz=1 or branch_taken=1.
- When undefined: fwd_sel_rn and fwd_sel_rm are tied to 00, and the full RAW stall above applies.

Test Plan:
1. rst pulse mid-wait (mfz=1 for 3 cycles) -> state RUN, stall_count=0, mem_timeout=0, all outputs 0 with idle inputs.
2. id_src_rn=3, id_uses_rn=1, exe_dest=3, exe_wb_en=1 (no macro) -> freeze_pc=freeze_if_id=bubble_id_exe=1, stall_count +1. With FORWARDING_EN and exe_mem_read=0 -> no stall, fwd_sel_rn=01.
3. mem_req=1, mem_ready low for 5 cycles then high -> freeze_pc/freeze_if_id/freeze_back high 5 cycles, stall_count=5, return to RUN. With MEM_TIMEOUT=4, mem_timeout=1 and it stays 1.
4. branch_taken=1 together with an EXE hazard on Rm -> flush_if_id=1, bubble_id_exe=1, freeze_pc=0, flush_count=1.
5. branch_taken=1 while mfz=1 -> only the freezes assert, flush_count unchanged. The cycle after mem_ready=1 -> flush asserted.
6. Force stall_count to 0xFFFE, then 3 hazard cycles -> stall_count holds at 0xFFFF.

Source files
------------

// File: rtl/hazard_freeze_ctrl.sv
// Pipeline freeze/flush/bubble sequencing for the 5-stage core.
// Optional operand forwarding is enabled by defining FORWARDING_EN.
module hazard_freeze_ctrl #(
  parameter int unsigned MEM_TIMEOUT = 64,
  parameter int unsigned CNT_W       = 16
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_id_valid,
  input  logic [3:0]       i_id_src_rn,
  input  logic [3:0]       i_id_src_rm,
  input  logic             i_id_uses_rn,
  input  logic             i_id_two_src,
  input  logic [3:0]       i_exe_dest,
  input  logic             i_exe_wb_en,
  input  logic             i_exe_mem_read,
  input  logic [3:0]       i_mem_dest,
  input  logic             i_mem_wb_en,
  input  logic             i_branch_taken,
  input  logic             i_mem_req,
  input  logic             i_mem_ready,
  output logic             o_freeze_pc,
  output logic             o_freeze_if_id,
  output logic             o_freeze_back,
  output logic             o_flush_if_id,
  output logic             o_bubble_id_exe,
  output logic [1:0]       o_fwd_sel_rn,
  output logic [1:0]       o_fwd_sel_rm,
  output logic [CNT_W-1:0] o_stall_count,
  output logic [CNT_W-1:0] o_flush_count,
  output logic             o_mem_timeout
);

  typedef enum logic {
    S_RUN,
    S_MEM_WAIT
  } state_t;

  localparam logic [15:0] LP_TO    = 16'(MEM_TIMEOUT);
  localparam logic [15:0] LP_TO_M1 = 16'(MEM_TIMEOUT - 1);
  localparam logic [CNT_W-1:0] LP_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

  state_t           r_state;
  state_t           w_next_state;
  logic [15:0]      r_wait_cnt;
  logic [15:0]      w_next_wait;
  logic [CNT_W-1:0] r_stall_count;
  logic [CNT_W-1:0] r_flush_count;
  logic             r_mem_timeout;

  logic w_mfz;
  logic w_rn_exe, w_rm_exe, w_rn_mem, w_rm_mem;
  logic w_hz_exe, w_hz_mem, w_hz;
  logic w_branch_flush;
  logic w_freeze_pc, w_freeze_if_id, w_freeze_back;
  logic w_flush_if_id, w_bubble_id_exe;
  logic [1:0] w_fwd_rn, w_fwd_rm;

  assign w_mfz = i_mem_req & ~i_mem_ready;

  assign w_rn_exe = i_id_valid & i_id_uses_rn & i_exe_wb_en
                  & (i_exe_dest == i_id_src_rn);
  assign w_rm_exe = i_id_valid & i_id_two_src & i_exe_wb_en
                  & (i_exe_dest == i_id_src_rm);
  assign w_rn_mem = i_id_valid & i_id_uses_rn & i_mem_wb_en
                  & (i_mem_dest == i_id_src_rn);
  assign w_rm_mem = i_id_valid & i_id_two_src & i_mem_wb_en
                  & (i_mem_dest == i_id_src_rm);

  assign w_hz_exe = w_rn_exe | w_rm_exe;
  assign w_hz_mem = w_rn_mem | w_rm_mem;

`ifdef FORWARDING_EN
  assign w_hz = w_hz_exe & i_exe_mem_read;
`else
  assign w_hz = w_hz_exe | w_hz_mem;
`endif

  assign w_branch_flush = ~w_mfz & i_branch_taken;

  // Priority: memory freeze, then branch squash, then ID hazard stall
  always_comb begin
    w_freeze_pc     = 1'b0;
    w_freeze_if_id  = 1'b0;
    w_freeze_back   = 1'b0;
    w_flush_if_id   = 1'b0;
    w_bubble_id_exe = 1'b0;
    if (w_mfz) begin
      w_freeze_pc    = 1'b1;
      w_freeze_if_id = 1'b1;
      w_freeze_back  = 1'b1;
    end else if (i_branch_taken) begin
      w_flush_if_id   = 1'b1;
      w_bubble_id_exe = 1'b1;
    end else if (w_hz) begin
      w_freeze_pc     = 1'b1;
      w_freeze_if_id  = 1'b1;
      w_bubble_id_exe = 1'b1;
    end
  end

  // Operand source select; EXE result wins over MEM result
  always_comb begin
    w_fwd_rn = 2'b00;
    w_fwd_rm = 2'b00;
`ifdef FORWARDING_EN
    if (!w_mfz && !i_branch_taken && !w_hz) begin
      if (w_rn_exe)      w_fwd_rn = 2'b01;
      else if (w_rn_mem) w_fwd_rn = 2'b10;
      if (w_rm_exe)      w_fwd_rm = 2'b01;
      else if (w_rm_mem) w_fwd_rm = 2'b10;
    end
`endif
  end

  // Next state and wait counter for the memory handshake
  always_comb begin
    w_next_state = r_state;
    w_next_wait  = r_wait_cnt;
    unique case (r_state)
      S_RUN: begin
        if (w_mfz) begin
          w_next_state = S_MEM_WAIT;
          w_next_wait  = 16'd1;
        end
      end
      S_MEM_WAIT: begin
        if (w_mfz) begin
          if (r_wait_cnt < LP_TO)
            w_next_wait = r_wait_cnt + 16'd1;
        end else begin
          w_next_state = S_RUN;
          w_next_wait  = 16'd0;
        end
      end
      default: begin
        w_next_state = S_RUN;
        w_next_wait  = 16'd0;
      end
    endcase
  end

  // State register and wait counter
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_RUN;
      r_wait_cnt <= 16'd0;
    end else begin
      r_state    <= w_next_state;
      r_wait_cnt <= w_next_wait;
    end
  end

  // Saturating stall/flush counters and sticky timeout flag
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_stall_count <= '0;
      r_flush_count <= '0;
      r_mem_timeout <= 1'b0;
    end else begin
      if (w_freeze_pc && (r_stall_count != '1))
        r_stall_count <= r_stall_count + LP_ONE;
      if (w_branch_flush && (r_flush_count != '1))
        r_flush_count <= r_flush_count + LP_ONE;
      if (w_mfz && (r_wait_cnt == LP_TO_M1))
        r_mem_timeout <= 1'b1;
    end
  end

  assign o_freeze_pc     = w_freeze_pc;
  assign o_freeze_if_id  = w_freeze_if_id;
  assign o_freeze_back   = w_freeze_back;
  assign o_flush_if_id   = w_flush_if_id;
  assign o_bubble_id_exe = w_bubble_id_exe;
  assign o_fwd_sel_rn    = w_fwd_rn;
  assign o_fwd_sel_rm    = w_fwd_rm;
  assign o_stall_count   = r_stall_count;
  assign o_flush_count   = r_flush_count;
  assign o_mem_timeout   = r_mem_timeout;

endmodule

// File: tb/tb_hazard_freeze_ctrl.sv
// Directed bench for hazard_freeze_ctrl (MEM_TIMEOUT=4).
// Expectations follow FORWARDING_EN when the macro is defined.
module tb_hazard_freeze_ctrl;

  logic        clk;
  logic        rst;
  logic        id_valid;
  logic [3:0]  id_src_rn;
  logic [3:0]  id_src_rm;
  logic        id_uses_rn;
  logic        id_two_src;
  logic [3:0]  exe_dest;
  logic        exe_wb_en;
  logic        exe_mem_read;
  logic [3:0]  mem_dest;
  logic        mem_wb_en;
  logic        branch_taken;
  logic        mem_req;
  logic        mem_ready;
  logic        freeze_pc;
  logic        freeze_if_id;
  logic        freeze_back;
  logic        flush_if_id;
  logic        bubble_id_exe;
  logic [1:0]  fwd_sel_rn;
  logic [1:0]  fwd_sel_rm;
  logic [15:0] stall_count;
  logic [15:0] flush_count;
  logic        mem_timeout;

  int passed;
  int total;
  int exp_stall;
  int exp_flush;

  hazard_freeze_ctrl #(
    .MEM_TIMEOUT(4),
    .CNT_W(16)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .i_id_valid(id_valid),
    .i_id_src_rn(id_src_rn),
    .i_id_src_rm(id_src_rm),
    .i_id_uses_rn(id_uses_rn),
    .i_id_two_src(id_two_src),
    .i_exe_dest(exe_dest),
    .i_exe_wb_en(exe_wb_en),
    .i_exe_mem_read(exe_mem_read),
    .i_mem_dest(mem_dest),
    .i_mem_wb_en(mem_wb_en),
    .i_branch_taken(branch_taken),
    .i_mem_req(mem_req),
    .i_mem_ready(mem_ready),
    .o_freeze_pc(freeze_pc),
    .o_freeze_if_id(freeze_if_id),
    .o_freeze_back(freeze_back),
    .o_flush_if_id(flush_if_id),
    .o_bubble_id_exe(bubble_id_exe),
    .o_fwd_sel_rn(fwd_sel_rn),
    .o_fwd_sel_rm(fwd_sel_rm),
    .o_stall_count(stall_count),
    .o_flush_count(flush_count),
    .o_mem_timeout(mem_timeout)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic set_idle();
    id_valid     = 1'b0;
    id_src_rn    = 4'd0;
    id_src_rm    = 4'd0;
    id_uses_rn   = 1'b0;
    id_two_src   = 1'b0;
    exe_dest     = 4'd0;
    exe_wb_en    = 1'b0;
    exe_mem_read = 1'b0;
    mem_dest     = 4'd0;
    mem_wb_en    = 1'b0;
    branch_taken = 1'b0;
    mem_req      = 1'b0;
    mem_ready    = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    set_idle();
    #12;
    total++;
    if ({freeze_pc, freeze_if_id, freeze_back, flush_if_id,
         bubble_id_exe, fwd_sel_rn, fwd_sel_rm} !== 9'd0)
      $display("FAIL rst_ctrl got %b exp 0",
               {freeze_pc, freeze_if_id, freeze_back, flush_if_id,
                bubble_id_exe, fwd_sel_rn, fwd_sel_rm});
    else passed++;
    total++;
    if (stall_count !== 16'd0 || flush_count !== 16'd0 || mem_timeout !== 1'b0)
      $display("FAIL rst_regs got %h/%h/%b exp 0/0/0",
               stall_count, flush_count, mem_timeout);
    else passed++;
    tick();
    rst = 1'b0;
    mem_req = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (stall_count !== 16'd3)
      $display("FAIL wait_stall got %0d exp 3", stall_count);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (stall_count !== 16'd0 || mem_timeout !== 1'b0)
      $display("FAIL midwait_rst got %0d/%b exp 0/0", stall_count, mem_timeout);
    else passed++;
    set_idle();
    #1;
    total++;
    if ({freeze_pc, freeze_if_id, freeze_back, bubble_id_exe} !== 4'd0)
      $display("FAIL midwait_idle got %b exp 0000",
               {freeze_pc, freeze_if_id, freeze_back, bubble_id_exe});
    else passed++;
    tick();
    rst = 1'b0;
    exp_stall = 0;
    exp_flush = 0;
  endtask

  task automatic test_hazard();
    logic       e_fpc;
    logic [1:0] e_rn;
    logic [1:0] e_rm;
    for (int k = 0; k < 5; k++) begin
      set_idle();
      e_fpc = 1'b0;
      e_rn  = 2'b00;
      e_rm  = 2'b00;
      case (k)
        0: begin
          id_valid = 1'b1; id_uses_rn = 1'b1; id_src_rn = 4'd3;
          exe_dest = 4'd3; exe_wb_en = 1'b1;
`ifdef FORWARDING_EN
          e_rn = 2'b01;
`else
          e_fpc = 1'b1;
`endif
        end
        1: begin
          id_valid = 1'b1; id_two_src = 1'b1; id_src_rm = 4'd5;
          mem_dest = 4'd5; mem_wb_en = 1'b1;
          exe_dest = 4'd6; exe_wb_en = 1'b1;
`ifdef FORWARDING_EN
          e_rm = 2'b10;
`else
          e_fpc = 1'b1;
`endif
        end
        2: begin
          id_valid = 1'b1; id_uses_rn = 1'b1; id_src_rn = 4'd15;
          exe_dest = 4'd15; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
          e_fpc = 1'b1;
        end
        3: begin
          id_uses_rn = 1'b1; id_src_rn = 4'd3;
          exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        end
        default: begin
          id_valid = 1'b1; id_src_rn = 4'd3;
          exe_dest = 4'd3; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
        end
      endcase
      #1;
      total++;
      if (freeze_pc !== e_fpc || freeze_if_id !== e_fpc)
        $display("FAIL hz%0d_freeze got %b%b exp %b%b",
                 k, freeze_pc, freeze_if_id, e_fpc, e_fpc);
      else passed++;
      total++;
      if (bubble_id_exe !== e_fpc || freeze_back !== 1'b0)
        $display("FAIL hz%0d_bubble got %b/%b exp %b/0",
                 k, bubble_id_exe, freeze_back, e_fpc);
      else passed++;
      total++;
      if (fwd_sel_rn !== e_rn)
        $display("FAIL hz%0d_fwd_rn got %b exp %b", k, fwd_sel_rn, e_rn);
      else passed++;
      total++;
      if (fwd_sel_rm !== e_rm)
        $display("FAIL hz%0d_fwd_rm got %b exp %b", k, fwd_sel_rm, e_rm);
      else passed++;
      tick();
      exp_stall += int'(e_fpc);
      total++;
      if (stall_count !== 16'(exp_stall))
        $display("FAIL hz%0d_stall got %0d exp %0d", k, stall_count, exp_stall);
      else passed++;
    end
    set_idle();
  endtask

  task automatic test_mem_wait();
    set_idle();
    mem_req = 1'b1;
    for (int i = 0; i < 5; i++) begin
      #1;
      total++;
      if ({freeze_pc, freeze_if_id, freeze_back, flush_if_id,
           bubble_id_exe} !== 5'b11100)
        $display("FAIL mw%0d_ctrl got %b exp 11100", i,
                 {freeze_pc, freeze_if_id, freeze_back, flush_if_id,
                  bubble_id_exe});
      else passed++;
      if (i == 3) begin
        total++;
        if (mem_timeout !== 1'b0)
          $display("FAIL mw_early_to got %b exp 0", mem_timeout);
        else passed++;
      end
      tick();
    end
    mem_ready = 1'b1;
    #1;
    total++;
    if ({freeze_pc, freeze_if_id, freeze_back} !== 3'b000)
      $display("FAIL mw_release got %b exp 000",
               {freeze_pc, freeze_if_id, freeze_back});
    else passed++;
    exp_stall += 5;
    total++;
    if (stall_count !== 16'(exp_stall))
      $display("FAIL mw_stall got %0d exp %0d", stall_count, exp_stall);
    else passed++;
    total++;
    if (mem_timeout !== 1'b1)
      $display("FAIL mw_timeout got %b exp 1", mem_timeout);
    else passed++;
    tick();
    set_idle();
    tick();
    tick();
    total++;
    if (mem_timeout !== 1'b1 || stall_count !== 16'(exp_stall))
      $display("FAIL mw_sticky got %b/%0d exp 1/%0d",
               mem_timeout, stall_count, exp_stall);
    else passed++;
  endtask

  task automatic test_branch();
    set_idle();
    branch_taken = 1'b1;
    id_valid = 1'b1; id_two_src = 1'b1; id_src_rm = 4'd7;
    exe_dest = 4'd7; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    #1;
    total++;
    if ({flush_if_id, bubble_id_exe, freeze_pc, freeze_if_id,
         freeze_back} !== 5'b11000)
      $display("FAIL br_ctrl got %b exp 11000",
               {flush_if_id, bubble_id_exe, freeze_pc, freeze_if_id,
                freeze_back});
    else passed++;
    total++;
    if (fwd_sel_rm !== 2'b00)
      $display("FAIL br_fwd got %b exp 00", fwd_sel_rm);
    else passed++;
    tick();
    exp_flush += 1;
    total++;
    if (flush_count !== 16'(exp_flush) || stall_count !== 16'(exp_stall))
      $display("FAIL br_count got %0d/%0d exp %0d/%0d",
               flush_count, stall_count, exp_flush, exp_stall);
    else passed++;
    set_idle();
  endtask

  task automatic test_branch_in_wait();
    set_idle();
    mem_req = 1'b1;
    branch_taken = 1'b1;
    #1;
    total++;
    if ({freeze_pc, freeze_if_id, freeze_back, flush_if_id,
         bubble_id_exe} !== 5'b11100)
      $display("FAIL brw_ctrl got %b exp 11100",
               {freeze_pc, freeze_if_id, freeze_back, flush_if_id,
                bubble_id_exe});
    else passed++;
    tick();
    tick();
    exp_stall += 2;
    total++;
    if (flush_count !== 16'(exp_flush) || stall_count !== 16'(exp_stall))
      $display("FAIL brw_count got %0d/%0d exp %0d/%0d",
               flush_count, stall_count, exp_flush, exp_stall);
    else passed++;
    mem_ready = 1'b1;
    #1;
    total++;
    if ({flush_if_id, bubble_id_exe, freeze_pc} !== 3'b110)
      $display("FAIL brw_flush got %b exp 110",
               {flush_if_id, bubble_id_exe, freeze_pc});
    else passed++;
    tick();
    exp_flush += 1;
    total++;
    if (flush_count !== 16'(exp_flush))
      $display("FAIL brw_fcount got %0d exp %0d", flush_count, exp_flush);
    else passed++;
    set_idle();
  endtask

  task automatic test_saturation();
    int n;
    set_idle();
    id_valid = 1'b1; id_uses_rn = 1'b1; id_src_rn = 4'd2;
    exe_dest = 4'd2; exe_wb_en = 1'b1; exe_mem_read = 1'b1;
    n = 16'hFFFE - exp_stall;
    repeat (n) @(posedge clk);
    #1;
    total++;
    if (stall_count !== 16'hFFFE)
      $display("FAIL sat_pre got %h exp fffe", stall_count);
    else passed++;
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (stall_count !== 16'hFFFF)
      $display("FAIL sat_hold got %h exp ffff", stall_count);
    else passed++;
    total++;
    if (freeze_pc !== 1'b1)
      $display("FAIL sat_fpc got %b exp 1", freeze_pc);
    else passed++;
    set_idle();
  endtask

  initial begin
    passed = 0;
    total = 0;
    exp_stall = 0;
    exp_flush = 0;
    test_reset();
    test_hazard();
    test_mem_wait();
    test_branch();
    test_branch_in_wait();
    test_saturation();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
